// File: rtl/pia_bus_pkg.sv
// Shared definitions for the PIA strobe-bus initiator: default widths, FSM states
// and the PIA register map.
package pia_bus_pkg;

    localparam int unsigned PIA_ADR_W = 7;
    localparam int unsigned PIA_DAT_W = 8;
    localparam int unsigned PIA_LEN_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_CAPTURE,
        S_RESP
    } state_e;

    localparam logic [PIA_ADR_W-1:0] PIA_SWCHA  = 7'h00;
    localparam logic [PIA_ADR_W-1:0] PIA_SWACNT = 7'h01;
    localparam logic [PIA_ADR_W-1:0] PIA_SWCHB  = 7'h02;
    localparam logic [PIA_ADR_W-1:0] PIA_SWBCNT = 7'h03;
    localparam logic [PIA_ADR_W-1:0] PIA_INTIM  = 7'h04;
    localparam logic [PIA_ADR_W-1:0] PIA_INSTAT = 7'h05;
    localparam logic [PIA_ADR_W-1:0] PIA_TIM1T  = 7'h14;
    localparam logic [PIA_ADR_W-1:0] PIA_TIM8T  = 7'h15;
    localparam logic [PIA_ADR_W-1:0] PIA_TIM64T = 7'h16;
    localparam logic [PIA_ADR_W-1:0] PIA_T1024T = 7'h17;

endpackage

// File: rtl/pia_bus_initiator_if.sv
// Request/response stream plus strobe-bus signals of the PIA bus initiator.
// master is the initiator's view, slave is the host/target environment's view.
interface pia_bus_initiator_if
    import pia_bus_pkg::*;
#(
    parameter int unsigned ADR_W = PIA_ADR_W,
    parameter int unsigned DAT_W = PIA_DAT_W,
    parameter int unsigned LEN_W = PIA_LEN_W
) ();

    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_we_i;
    logic [ADR_W-1:0] req_adr_i;
    logic [DAT_W-1:0] req_dat_i;
    logic [LEN_W-1:0] req_len_i;
    logic             req_inc_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_last_o;
    logic             stb_o;
    logic             we_o;
    logic [ADR_W-1:0] adr_o;
    logic [DAT_W-1:0] dat_o;
    logic [DAT_W-1:0] dat_i;
    logic             busy_o;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_len_i, req_inc_i,
        input  rsp_ready_i, dat_i,
        output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_last_o,
        output stb_o, we_o, adr_o, dat_o, busy_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_len_i, req_inc_i,
        output rsp_ready_i, dat_i,
        input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_last_o,
        input  stb_o, we_o, adr_o, dat_o, busy_o
    );

endinterface

// File: rtl/pia_bus_initiator.sv
// Converts valid/ready burst requests into one-strobe-per-beat bus cycles on the
// PIA strobe bus, returning one response beat per access.
module pia_bus_initiator
    import pia_bus_pkg::*;
#(
    parameter int unsigned ADR_W = PIA_ADR_W,
    parameter int unsigned DAT_W = PIA_DAT_W,
    parameter int unsigned LEN_W = PIA_LEN_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    pia_bus_initiator_if.master bus
);

    state_e           r_state;
    logic             r_we;
    logic             r_inc;
    logic             r_stb;
    logic [ADR_W-1:0] r_adr;
    logic [DAT_W-1:0] r_dat;
    logic [LEN_W-1:0] r_cnt;
    logic             r_rsp_valid;
    logic [DAT_W-1:0] r_rsp_dat;
    logic             r_rsp_last;
    logic [ADR_W-1:0] w_adr_nxt;

    // Address wraps naturally at ADR_W bits
    assign w_adr_nxt = r_inc ? r_adr + 1'b1 : r_adr;

    // The latched request registers double as the bus outputs: they only change
    // on the edge that enters STROBE, so they hold their values elsewhere.
    assign bus.stb_o       = r_stb;
    assign bus.we_o        = r_we;
    assign bus.adr_o       = r_adr;
    assign bus.dat_o       = r_dat;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_dat_o   = r_rsp_dat;
    assign bus.rsp_last_o  = r_rsp_last;
    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.req_ready_o = (r_state == S_IDLE) && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_inc       <= 1'b0;
            r_stb       <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid_i) begin
                        r_we    <= bus.req_we_i;
                        r_adr   <= bus.req_adr_i;
                        r_dat   <= bus.req_dat_i;
                        r_inc   <= bus.req_inc_i;
                        r_cnt   <= bus.req_len_i;
                        r_stb   <= 1'b1;
                        r_state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    r_stb   <= 1'b0;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_rsp_dat   <= r_we ? '0 : bus.dat_i;
                    r_rsp_last  <= (r_cnt == '0);
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt - 1'b1;
                            r_adr   <= w_adr_nxt;
                            r_stb   <= 1'b1;
                            r_state <= S_STROBE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
